// File: rtl/reg_ring_pkg.sv
// rtl/reg_ring_pkg.sv - shared constants and FSM encoding for the register ring master
package reg_ring_pkg;

  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SRC_WIDTH  = 2;
  localparam int STALE_WIDTH    = 16;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/reg_ring_timer.sv
// rtl/reg_ring_timer.sv - clearable WAIT-cycle counter with terminal count at TIMEOUT-1
module reg_ring_timer #(
  parameter int TIMEOUT = 127
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/reg_ring_master.sv
// rtl/reg_ring_master.sv - single-outstanding register ring initiator with timeout
module reg_ring_master
  import reg_ring_pkg::*;
#(
  parameter int UDP_REG_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int CPCI_NF2_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int UDP_REG_SRC_WIDTH   = DEF_SRC_WIDTH,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID = '0,
  parameter int TIMEOUT = 127
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_rd_wr_L,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] cmd_wr_data,
  output logic                           rsp_valid,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_data,
  output logic                           rsp_timeout,
  output logic                           rsp_noack,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);

  logic [1:0]                     state_q, state_d;
  logic                           cmd_ready_q, cmd_ready_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                           rsp_timeout_q, rsp_timeout_d;
  logic                           rsp_noack_q, rsp_noack_d;
  logic                           req_q, req_d;
  logic                           rd_wr_L_q, rd_wr_L_d;
  logic [UDP_REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_q, src_d;
  logic [STALE_WIDTH-1:0]         stale_cnt_q, stale_cnt_d;

  logic timer_clear, timer_en, timer_tc;
  logic ret_match;
  logic unused_ring_in;

  // Returned address and direction are deliberately not checked.
  assign unused_ring_in = ^{reg_addr_in, reg_rd_wr_L_in};
  assign ret_match = reg_req_in && (reg_src_in == SRC_ID);

  reg_ring_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_noack_d   = rsp_noack_q;
    req_d         = 1'b0;
    rd_wr_L_d     = 1'b0;
    addr_d        = '0;
    data_d        = '0;
    src_d         = '0;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;
    stale_cnt_d   = stale_cnt_q;

    // Late returns after a timeout land here; saturate rather than wrap.
    if (ret_match && (state_q != ST_WAIT) && (stale_cnt_q != '1)) begin
      stale_cnt_d = stale_cnt_q + STALE_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_ISSUE;
          req_d     = 1'b1;
          rd_wr_L_d = cmd_rd_wr_L;
          addr_d    = cmd_addr;
          data_d    = cmd_rd_wr_L ? '0 : cmd_wr_data;
          src_d     = SRC_ID;
        end
      end
      ST_ISSUE: begin
        state_d     = ST_WAIT;
        timer_clear = 1'b1;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (ret_match) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = reg_data_in;
          rsp_noack_d = !reg_ack_in;
        end else if (timer_tc) begin
          state_d       = ST_DONE;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = CPCI_NF2_DATA_WIDTH'(TIMEOUT_DATA);
          rsp_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        rsp_data_d    = '0;
        rsp_timeout_d = 1'b0;
        rsp_noack_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_noack_q   <= 1'b0;
      req_q         <= 1'b0;
      rd_wr_L_q     <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      src_q         <= '0;
      stale_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_noack_q   <= rsp_noack_d;
      req_q         <= req_d;
      rd_wr_L_q     <= rd_wr_L_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      src_q         <= src_d;
      stale_cnt_q   <= stale_cnt_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign rsp_noack       = rsp_noack_q;
  assign reg_req_out     = req_q;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = rd_wr_L_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;

endmodule

// File: tb/tb_reg_ring_master.sv
// tb/tb_reg_ring_master.sv - directed and random transactions against a cycle-level ring model
module tb_reg_ring_master;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 8;
  localparam logic [SW-1:0] SID = 2'd1;
  localparam int KMAX = TO + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rd_wr_L = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wr_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout, rsp_noack;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [SW-1:0] reg_src_in = '0;

  int n_checks = 0;
  int n_fail = 0;
  int exp_stale = 0;

  always #5 clk = ~clk;

  reg_ring_master #(
    .UDP_REG_ADDR_WIDTH(AW), .CPCI_NF2_DATA_WIDTH(DW), .UDP_REG_SRC_WIDTH(SW),
    .SRC_ID(SID), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr_L(cmd_rd_wr_L),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_noack(rsp_noack),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_flags"}, 32'({rsp_timeout, rsp_noack}), 32'd0);
    check({tag, "_ring_ctl"}, 32'({reg_req_out, reg_ack_out, reg_rd_wr_L_out}), 32'd0);
    check({tag, "_ring_addr"}, 32'(reg_addr_out), 32'd0);
    check({tag, "_ring_data"}, reg_data_out, 32'd0);
    check({tag, "_ring_src"}, 32'(reg_src_out), 32'd0);
    check({tag, "_stale"}, 32'(dut.stale_cnt_q), 32'(exp_stale));
  endtask

  // d: return arrives d cycles after the reg_req_out cycle (0 = never).
  // fk: a foreign-tag return is injected at that offset (0 = never).
  task automatic run_txn(input string tag, input logic rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int d, input logic ack,
                         input logic [DW-1:0] rdata, input int fk, input logic [SW-1:0] fsrc);
    bit in_window;
    int exp_k;
    in_window = (d >= 1) && (d <= TO);
    exp_k = in_window ? d + 1 : TO + 1;

    check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_rd_wr_L = rd; cmd_addr = addr; cmd_wr_data = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rd_wr_L = 1'($urandom); cmd_addr = AW'($urandom); cmd_wr_data = $urandom;
    check({tag, "_req"}, 32'({reg_req_out, reg_ack_out}), 32'b10);
    check({tag, "_req_src"}, 32'(reg_src_out), 32'(SID));
    check({tag, "_req_rdwr"}, 32'(reg_rd_wr_L_out), 32'(rd));
    check({tag, "_req_addr"}, 32'(reg_addr_out), 32'(addr));
    check({tag, "_req_data"}, reg_data_out, rd ? 32'd0 : wdata);
    check({tag, "_ready_busy"}, 32'(cmd_ready), 32'd0);

    for (int k = 1; k <= KMAX; k++) begin
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(k == exp_k));
      check({tag, "_ready"}, 32'(cmd_ready), 32'(k > exp_k));
      if (k == exp_k) begin
        check({tag, "_rsp_data"}, rsp_data, in_window ? rdata : 32'hDEAD_BEEF);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(!in_window));
        check({tag, "_rsp_noack"}, 32'(rsp_noack), 32'(in_window && !ack));
      end else begin
        check({tag, "_flags_quiet"}, 32'({rsp_timeout, rsp_noack, reg_req_out}), 32'd0);
      end
      reg_addr_in = AW'($urandom); reg_rd_wr_L_in = 1'($urandom);
      if (k == d) begin
        reg_req_in = 1'b1; reg_src_in = SID; reg_ack_in = ack; reg_data_in = rdata;
        if (k > TO) exp_stale++;
      end else if (k == fk) begin
        reg_req_in = 1'b1; reg_src_in = fsrc; reg_ack_in = 1'($urandom); reg_data_in = $urandom;
      end else begin
        reg_req_in = 1'b0; reg_src_in = SW'($urandom); reg_ack_in = 1'($urandom);
        reg_data_in = $urandom;
      end
    end
    @(negedge clk);
    reg_req_in = 1'b0;
    check({tag, "_stale"}, 32'(dut.stale_cnt_q), 32'(exp_stale));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_txn("wr_loop", 1'b0, 23'h000100, 32'h1234_5678, 1, 1'b1, 32'h1234_5678, 0, 2'd0);
    run_txn("rd_5", 1'b1, 23'h00_0ABC, 32'h5555_AAAA, 5, 1'b1, 32'hCAFE_F00D, 0, 2'd0);
    run_txn("timeout", 1'b1, 23'h7F_FFFF, 32'h0, TO + 4, 1'b1, 32'h0BAD_0BAD, 0, 2'd0);
    run_txn("noack", 1'b0, 23'h00_0010, 32'hA5A5_5A5A, 3, 1'b0, 32'hA5A5_5A5A, 0, 2'd0);
    run_txn("foreign", 1'b1, 23'h00_0020, 32'h0, 5, 1'b1, 32'h1111_2222, 2, SID + 2'd1);
    run_txn("tc_match", 1'b1, 23'h00_0030, 32'h0, TO, 1'b1, 32'h3333_4444, 0, 2'd0);

    // Reset in the middle of WAIT must abort silently.
    cmd_valid = 1'b1; cmd_rd_wr_L = 1'b0; cmd_addr = 23'h00_0040; cmd_wr_data = 32'hFEED_0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_stale = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_valid", 32'(rsp_valid), 32'd0);
    run_txn("after_reset", 1'b0, 23'h00_0050, 32'hFEED_0002, 2, 1'b1, 32'hFEED_0002, 0, 2'd0);

    for (int i = 0; i < 24; i++) begin
      logic rd;
      logic [DW-1:0] wd;
      rd = 1'($urandom);
      wd = $urandom;
      run_txn("rand", rd, AW'($urandom), wd, int'($urandom_range(0, KMAX)), 1'($urandom),
              rd ? $urandom : wd, int'($urandom_range(0, KMAX)),
              SID ^ SW'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
